// File: rtl/link_control_if.sv
// Link sequencer bus: player buttons, frame/draw handshakes, state strobes and draw windows.
// master = link_control, slave = datapath/environment side.
interface link_control_if;
    logic start;
    logic btn_up;
    logic btn_down;
    logic btn_left;
    logic btn_right;
    logic btn_attack;
    logic frame_tick;
    logic map_done;
    logic draw_done;
    logic init;
    logic idle;
    logic attack;
    logic move_up;
    logic move_down;
    logic move_left;
    logic move_right;
    logic draw_map;
    logic draw_char;
    logic overrun;

    modport master (
        input  start, btn_up, btn_down, btn_left, btn_right, btn_attack,
        input  frame_tick, map_done, draw_done,
        output init, idle, attack, move_up, move_down, move_left, move_right,
        output draw_map, draw_char, overrun
    );

    modport slave (
        output start, btn_up, btn_down, btn_left, btn_right, btn_attack,
        output frame_tick, map_done, draw_done,
        input  init, idle, attack, move_up, move_down, move_left, move_right,
        input  draw_map, draw_char, overrun
    );
endinterface

// File: rtl/link_control.sv
// Per-frame sequencer for the Link character datapath: map redraw, one state strobe, char draw.
// Optional LINK_CTRL_WATCHDOG_EN adds a draw timeout that forces S_WAIT and sets sticky wd_fault.
//
// state    | meaning
// S_RESET  | idle after reset, waiting for start
// S_INIT   | one-cycle init strobe
// S_WAIT   | waiting for frame_tick or a pending frame
// S_MAP    | draw_map window, waiting for map_done
// S_UPDATE | one strobe chosen from attack/move/idle
// S_CHAR   | draw_char window, waiting for draw_done
module link_control #(
    parameter int unsigned ATTACK_FRAMES  = 8,
    parameter int unsigned MOVE_DIV       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clock,
    input  logic reset,
`ifdef LINK_CTRL_WATCHDOG_EN
    output logic wd_fault,
`endif
    link_control_if.master lif
);

    typedef enum logic [2:0] {
        S_RESET, S_INIT, S_WAIT, S_MAP, S_UPDATE, S_CHAR
    } state_t;

    localparam logic [7:0] ATK_LOAD = 8'(ATTACK_FRAMES - 1);
    localparam logic [3:0] DIV_LAST = 4'(MOVE_DIV - 1);

    if (ATTACK_FRAMES < 1 || ATTACK_FRAMES > 255 || MOVE_DIV < 1 || MOVE_DIV > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("link_control: parameter out of range");
    end

    state_t     state_q, state_d;
    logic [4:0] sync1_q, sync2_q;   // {attack, right, left, down, up}
    logic       atk_prev_q;
    logic       atk_req_q, atk_req_d;
    logic [7:0] atk_cnt_q, atk_cnt_d;
    logic [3:0] div_cnt_q, div_cnt_d;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       atk_edge;

`ifdef LINK_CTRL_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        wd_fault_q, wd_fault_d;
    logic        wd_active;
`endif

    assign atk_edge    = sync2_q[4] & ~atk_prev_q;
    assign lif.overrun = overrun_q;

    always_comb begin
        state_d        = state_q;
        atk_req_d      = atk_req_q;
        atk_cnt_d      = atk_cnt_q;
        div_cnt_d      = div_cnt_q;
        pending_d      = pending_q;
        overrun_d      = overrun_q;
        lif.init       = 1'b0;
        lif.idle       = 1'b0;
        lif.attack     = 1'b0;
        lif.move_up    = 1'b0;
        lif.move_down  = 1'b0;
        lif.move_left  = 1'b0;
        lif.move_right = 1'b0;
        lif.draw_map   = 1'b0;
        lif.draw_char  = 1'b0;

        // Edges during an attack in progress are dropped, not queued.
        if (atk_edge && atk_cnt_q == 8'd0) atk_req_d = 1'b1;

        if (lif.frame_tick && state_q != S_WAIT) begin
            pending_d = 1'b1;
            overrun_d = 1'b1;
        end

        case (state_q)
            S_RESET: if (lif.start) state_d = S_INIT;
            S_INIT: begin
                lif.init = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (lif.frame_tick || pending_q) begin
                    state_d   = S_MAP;
                    pending_d = 1'b0;
                end
            end
            S_MAP: begin
                lif.draw_map = 1'b1;
                if (lif.map_done) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                state_d   = S_CHAR;
                div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
                if (atk_cnt_q != 8'd0) begin
                    lif.attack = 1'b1;
                    atk_cnt_d  = atk_cnt_q - 8'd1;
                end else if (atk_req_q) begin
                    lif.attack = 1'b1;
                    atk_cnt_d  = ATK_LOAD;
                    atk_req_d  = 1'b0;
                end else if (div_cnt_q == 4'd0 && sync2_q[0]) begin
                    lif.move_up = 1'b1;
                end else if (div_cnt_q == 4'd0 && sync2_q[1]) begin
                    lif.move_down = 1'b1;
                end else if (div_cnt_q == 4'd0 && sync2_q[2]) begin
                    lif.move_left = 1'b1;
                end else if (div_cnt_q == 4'd0 && sync2_q[3]) begin
                    lif.move_right = 1'b1;
                end else begin
                    lif.idle = 1'b1;
                end
            end
            S_CHAR: begin
                lif.draw_char = 1'b1;
                if (lif.draw_done) state_d = S_WAIT;
            end
            default: state_d = S_RESET;
        endcase

`ifdef LINK_CTRL_WATCHDOG_EN
        wd_cnt_d   = wd_cnt_q;
        wd_fault_d = wd_fault_q;
        wd_active  = (state_q == S_MAP) || (state_q == S_CHAR);
        if (wd_active && state_d == state_q && wd_cnt_q == WD_LAST) begin
            state_d    = S_WAIT;
            wd_fault_d = 1'b1;
        end
        if (state_d != state_q) wd_cnt_d = 16'd0;
        else if (wd_active)     wd_cnt_d = wd_cnt_q + 16'd1;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RESET;
            sync1_q    <= '0;
            sync2_q    <= '0;
            atk_prev_q <= 1'b0;
            atk_req_q  <= 1'b0;
            atk_cnt_q  <= '0;
            div_cnt_q  <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= {lif.btn_attack, lif.btn_right, lif.btn_left, lif.btn_down, lif.btn_up};
            sync2_q    <= sync1_q;
            atk_prev_q <= sync2_q[4];
            atk_req_q  <= atk_req_d;
            atk_cnt_q  <= atk_cnt_d;
            div_cnt_q  <= div_cnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef LINK_CTRL_WATCHDOG_EN
    assign wd_fault = wd_fault_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt_q   <= '0;
            wd_fault_q <= 1'b0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            wd_fault_q <= wd_fault_d;
        end
    end
`endif

endmodule

// File: tb/tb_link_control.sv
// Directed bench for link_control (ATTACK_FRAMES=3, MOVE_DIV=2): expected strobes go into a
// queue when map_done is issued and a negedge monitor pops/compares each strobe the DUT shows.
module tb_link_control;
    logic clock;
    logic reset;
    link_control_if lif ();

    localparam logic [6:0] E_INIT  = 7'b1000000;
    localparam logic [6:0] E_IDLE  = 7'b0100000;
    localparam logic [6:0] E_ATK   = 7'b0010000;
    localparam logic [6:0] E_UP    = 7'b0001000;
    localparam logic [6:0] E_RIGHT = 7'b0000001;

    int total = 0;
    int bad   = 0;
    logic [6:0] exp_q[$];

`ifdef LINK_CTRL_WATCHDOG_EN
    logic wd_fault;
    link_control #(.ATTACK_FRAMES(3), .MOVE_DIV(2), .TIMEOUT_CYCLES(100)) dut (
        .clock(clock), .reset(reset), .wd_fault(wd_fault), .lif(lif));
`else
    link_control #(.ATTACK_FRAMES(3), .MOVE_DIV(2), .TIMEOUT_CYCLES(100)) dut (
        .clock(clock), .reset(reset), .lif(lif));
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] strobes();
        return {lif.init, lif.idle, lif.attack, lif.move_up, lif.move_down,
                lif.move_left, lif.move_right};
    endfunction

    always @(negedge clock) begin
        logic [6:0] s;
        logic [6:0] e;
        s = strobes();
        if (s != 7'd0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected got=%b want=none t=%0t", s, $time);
            end else begin
                e = exp_q.pop_front();
                if (s !== e) begin
                    bad++;
                    $display("FAIL strobe got=%b want=%b t=%0t", s, e, $time);
                end
            end
        end
        total++;
        if (lif.draw_map && lif.draw_char) begin
            bad++;
            $display("FAIL draw_exclusive got=11 want=not_both t=%0t", $time);
        end
    end

    task automatic chk(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // with_tick=0 means the frame is already in S_MAP (pending frame).
    task automatic run_frame(input logic [6:0] exp, input int map_dly, input int char_dly,
                             input int extra_ticks, input logic with_tick, input logic tick_at_done);
        if (with_tick) begin
            lif.frame_tick = 1'b1;
            step();
            lif.frame_tick = 1'b0;
        end
        chk("draw_map_rise", lif.draw_map, 1'b1);
        repeat (map_dly) step();
        exp_q.push_back(exp);
        lif.map_done = 1'b1;
        step();
        lif.map_done = 1'b0;
        chk("draw_map_fall", lif.draw_map, 1'b0);
        step();
        chk("draw_char_rise", lif.draw_char, 1'b1);
        for (int i = 0; i < extra_ticks; i++) begin
            repeat (3) step();
            lif.frame_tick = 1'b1;
            step();
            lif.frame_tick = 1'b0;
        end
        repeat (char_dly) step();
        lif.draw_done  = 1'b1;
        lif.frame_tick = tick_at_done;
        step();
        lif.draw_done  = 1'b0;
        lif.frame_tick = 1'b0;
        chk("draw_char_fall", lif.draw_char, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        lif.start = 1'b1;
        {lif.btn_up, lif.btn_down, lif.btn_left, lif.btn_right, lif.btn_attack} = 5'b0;
        lif.frame_tick = 1'b0;
        lif.map_done   = 1'b0;
        lif.draw_done  = 1'b0;

        repeat (3) step();
        chk("rst_strobes_zero", strobes() == 7'd0, 1'b1);
        chk("rst_draw_map", lif.draw_map, 1'b0);
        chk("rst_draw_char", lif.draw_char, 1'b0);
        chk("rst_overrun", lif.overrun, 1'b0);

        exp_q.push_back(E_INIT);
        reset = 1'b1;
        step();
        chk("init_pulse", lif.init, 1'b1);
        step();
        chk("init_one_cycle", lif.init, 1'b0);
        repeat (5) step();
        chk("wait_quiet", strobes() == 7'd0 && !lif.draw_map && !lif.draw_char, 1'b1);

        // No buttons: div 0->1 then 1->0.
        run_frame(E_IDLE, 5, 20, 0, 1'b1, 1'b0);
        chk("no_overrun", lif.overrun, 1'b0);
        repeat (3) step();
        run_frame(E_IDLE, 2, 3, 0, 1'b1, 1'b0);

        // up+left held: up on move frames only, left never.
        lif.btn_up = 1'b1; lif.btn_left = 1'b1;
        repeat (4) step();
        run_frame(E_UP,   2, 3, 0, 1'b1, 1'b0);
        run_frame(E_IDLE, 2, 3, 0, 1'b1, 1'b0);
        run_frame(E_UP,   2, 3, 0, 1'b1, 1'b0);
        run_frame(E_IDLE, 2, 3, 0, 1'b1, 1'b0);
        lif.btn_up = 1'b0; lif.btn_left = 1'b0;

        // right held, div=0 -> move_right; then attack press (held) gives 3 attack frames.
        lif.btn_right = 1'b1;
        repeat (4) step();
        run_frame(E_RIGHT, 2, 3, 0, 1'b1, 1'b0);
        lif.btn_attack = 1'b1;
        repeat (5) step();
        run_frame(E_ATK,   2, 3, 0, 1'b1, 1'b0);
        run_frame(E_ATK,   2, 3, 0, 1'b1, 1'b0);
        run_frame(E_ATK,   2, 3, 0, 1'b1, 1'b0);
        run_frame(E_RIGHT, 2, 3, 0, 1'b1, 1'b0);
        run_frame(E_IDLE,  2, 3, 0, 1'b1, 1'b0);
        run_frame(E_RIGHT, 2, 3, 0, 1'b1, 1'b0);
        lif.btn_attack = 1'b0; lif.btn_right = 1'b0;
        repeat (4) step();

        // Two ticks during S_CHAR collapse into one pending frame.
        run_frame(E_IDLE, 2, 20, 2, 1'b1, 1'b0);
        chk("overrun_set", lif.overrun, 1'b1);
        step();
        chk("pending_frame_start", lif.draw_map, 1'b1);
        run_frame(E_IDLE, 2, 3, 0, 1'b0, 1'b0);
        repeat (10) step();
        chk("no_second_pending", lif.draw_map, 1'b0);

        // Tick coincident with draw_done: frame starts one cycle after S_WAIT.
        run_frame(E_IDLE, 2, 3, 0, 1'b1, 1'b1);
        chk("coincident_wait", lif.draw_map, 1'b0);
        step();
        chk("coincident_pending", lif.draw_map, 1'b1);
        run_frame(E_IDLE, 2, 3, 0, 1'b0, 1'b0);

        // Stray map_done/draw_done in S_WAIT are ignored.
        repeat (3) step();
        lif.map_done = 1'b1; lif.draw_done = 1'b1;
        step();
        lif.map_done = 1'b0; lif.draw_done = 1'b0;
        repeat (3) step();
        chk("stray_done_ignored", lif.draw_map || lif.draw_char, 1'b0);

        // Reset mid-S_CHAR drops draw_char asynchronously.
        lif.frame_tick = 1'b1;
        step();
        lif.frame_tick = 1'b0;
        step();
        exp_q.push_back(E_IDLE);
        lif.map_done = 1'b1;
        step();
        lif.map_done = 1'b0;
        step();
        chk("pre_reset_draw_char", lif.draw_char, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_draw_char", lif.draw_char, 1'b0);
        chk("async_reset_overrun", lif.overrun, 1'b0);
        lif.start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (10) step();
        chk("no_strobe_after_release", strobes() == 7'd0 && !lif.draw_map, 1'b1);
        chk("scoreboard_empty", exp_q.size() == 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/link_control.md
Name: link_control

Overview:
- Per-frame sequencer that sits directly upstream of the Link character datapath.
- Paces the game to a frame tick and samples the player buttons.
- Issues the one-cycle state strobes (init, idle, attack, move_*) and a draw_char window, then waits for the datapath's draw_done handshake.
- Also brackets the map redraw (draw_map/map_done) so the character is drawn after the background each frame.

Parameters:
- ATTACK_FRAMES, 8, frames an attack lasts once triggered (1..255).
- MOVE_DIV, 1, movement applied every MOVE_DIV frames (1..15); slows walking speed.
- TIMEOUT_CYCLES, 65535, watchdog limit in clocks (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; first high after reset launches init.
- btn_up, btn_down, btn_left, btn_right, btn_attack  in  1 each  raw active-high buttons, asynchronous to clock.
- frame_tick  in  1  one-cycle pulse per video frame.
- map_done  in  1  one-cycle pulse: map redraw complete.
- draw_done  in  1  one-cycle pulse: character draw complete.
- init, idle, attack, move_up, move_down, move_left, move_right  out  1 each  one-cycle strobes, at most one high per cycle.
- draw_map  out  1  level; high from map-draw entry until map_done is sampled.
- draw_char  out  1  level; high from char-draw entry until draw_done is sampled.
- overrun  out  1  sticky; a frame_tick arrived while not in S_WAIT.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs are 0; state is S_RESET.
  - Counters, the pending flag and the synchronisers are cleared.
  - Reset mid-draw aborts immediately. No strobe is issued on release.
- Buttons: each passes through a 2-flop synchroniser. btn_attack is additionally rising-edge detected on the synchronised value.
- States:
  - S_RESET: leave for S_INIT when start is 1.
  - S_INIT: init=1 for exactly one cycle, then S_WAIT.
  - S_WAIT: on frame_tick (or pending=1) go to S_MAP and clear pending.
  - S_MAP: draw_map=1; on map_done go to S_UPDATE.
  - S_UPDATE: exactly one strobe for one cycle, then S_CHAR.
  - S_CHAR: draw_char=1; on draw_done go to S_WAIT.
- Latency:
  - frame_tick at cycle T gives draw_map=1 at T+1.
  - map_done at T gives the strobe at T+1 and draw_char=1 at T+2.
  - draw_done at T gives draw_char=0 at T+1.
- Strobe selection in S_UPDATE (priority order):
  1. atk_cnt>0: attack=1, atk_cnt decrements.
  2. Attack edge latched since the last update: attack=1, atk_cnt loads ATTACK_FRAMES-1.
  3. Move frame (div_cnt==0) with a direction held, priority up>down>left>right: the matching move_* strobe.
  4. Otherwise: idle=1.
- Attack details:
  - The attack edge is latched into atk_req; atk_req is cleared when consumed.
  - Edges occurring while atk_cnt>0 are discarded.
- Movement divider:
  - div_cnt counts 0..MOVE_DIV-1 and advances once per S_UPDATE.
  - It wraps to 0 after MOVE_DIV-1.
  - MOVE_DIV=1 gives movement every frame.
- Overrun handling:
  - frame_tick outside S_WAIT sets pending=1 and overrun=1.
  - Multiple missed ticks collapse into one pending frame.
  - overrun clears only on reset.
- Simultaneous events:
  - frame_tick in the same cycle S_CHAR sees draw_done: the tick counts as pending and overrun is set. The next frame starts from S_WAIT one cycle later.
  - map_done or draw_done outside its matching state is ignored.
- Mutual exclusion: draw_map and draw_char are never both high. No two strobes are high together.

Optional Feature:
- Macro: LINK_CTRL_WATCHDOG_EN.
- Defined:
  - A 16-bit counter runs in S_MAP and S_CHAR. It is cleared on entry to either state.
  - Reaching TIMEOUT_CYCLES forces S_WAIT and drops draw_map/draw_char.
  - Adds output port wd_fault (1 bit, sticky, reset 0), which is set on the forced exit.
- Undefined: no counter and no wd_fault port. S_MAP and S_CHAR wait indefinitely.

Test Plan:
- Release reset with start=1 → init pulses exactly one cycle; all other outputs stay 0 until the first frame_tick.
- frame_tick, map_done 5 cycles later, draw_done 20 cycles after draw_char rises, no buttons → sequence draw_map, idle strobe, draw_char; back to S_WAIT; overrun=0.
- btn_up and btn_left held with MOVE_DIV=2 over 4 frames → move_up on frames 1 and 3, idle on frames 2 and 4; no move_left.
- btn_attack pressed once and held, ATTACK_FRAMES=3, btn_right held → attack on 3 consecutive frames, then move_right; holding the button does not retrigger.
- Two frame_ticks during S_CHAR → overrun=1; exactly one extra frame runs immediately after draw_done.
- Reset asserted mid-S_CHAR with draw_char=1 → draw_char=0 the same cycle asynchronously. With LINK_CTRL_WATCHDOG_EN and TIMEOUT_CYCLES=100, withholding map_done gives wd_fault=1 and draw_map=0 after 100 cycles.
